// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between I-cache (client 0) and D-cache (client 1).
// Optional BUSY watchdog under CACHE_ARB_TIMEOUT_EN; without it BUSY waits indefinitely.
module cache_mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int LINE_W         = 128,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c0_req,
    input  logic              c0_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [LINE_W-1:0] c0_wdata,
    output logic [LINE_W-1:0] c0_rdata,
    output logic              c0_ready,
    input  logic              c1_req,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [LINE_W-1:0] c1_wdata,
    output logic [LINE_W-1:0] c1_rdata,
    output logic              c1_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        grant,
    output logic              timeout_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_grant;
    logic                r_last;
    logic [1:0]          r_mask;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [LINE_W-1:0]   r_wdata;

    logic [1:0]          w_elig;
    logic [1:0]          w_pick;
    logic                w_timeout;
    logic                w_done;
    logic                w_mem_req;
    logic                w_c0_ready;
    logic                w_c1_ready;
    logic [LINE_W-1:0]   w_rdata;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [LINE_W-1:0]   w_sel_wdata;

    // The client served last is masked for one IDLE cycle so a late-dropping req is not re-granted.
    assign w_elig = {c1_req, c0_req} & ~r_mask;

    always_comb begin
        w_pick = 2'b00;
        case (w_elig)
            2'b01:   w_pick = 2'b01;
            2'b10:   w_pick = 2'b10;
            2'b11:   w_pick = r_last ? 2'b01 : 2'b10;
            default: w_pick = 2'b00;
        endcase
    end

    assign w_sel_we    = w_pick[1] ? c1_we    : c0_we;
    assign w_sel_addr  = w_pick[1] ? c1_addr  : c0_addr;
    assign w_sel_wdata = w_pick[1] ? c1_wdata : c0_wdata;

`ifdef CACHE_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout_err;

    assign w_timeout = (r_state == BUSY) && (r_cnt == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                r_cnt <= '0;
            end else if (!w_done) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign w_done = (r_state == BUSY) && (mem_ready || w_timeout);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mem_req   = 1'b0;
        w_c0_ready  = 1'b0;
        w_c1_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_pick) begin
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                w_mem_req = !w_timeout;
                if (w_done) begin
                    w_state_nxt = IDLE;
                    w_c0_ready  = r_grant[0];
                    w_c1_ready  = r_grant[1];
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant <= 2'b00;
            r_last  <= 1'b1;
            r_mask  <= 2'b00;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (r_state == IDLE) begin
            r_mask <= 2'b00;
            if (|w_pick) begin
                r_grant <= w_pick;
                r_we    <= w_sel_we;
                r_addr  <= w_sel_addr & ~ADDR_W'(15);
                r_wdata <= w_sel_wdata;
            end
        end else if (w_done) begin
            r_grant <= 2'b00;
            r_last  <= r_grant[1];
            r_mask  <= r_grant;
        end
    end

    // Aborted and write-back completions return an all-zero line.
    assign w_rdata = (!r_we && !w_timeout) ? mem_rdata : '0;

    assign c0_ready  = w_c0_ready;
    assign c1_ready  = w_c1_ready;
    assign c0_rdata  = w_c0_ready ? w_rdata : '0;
    assign c1_rdata  = w_c1_ready ? w_rdata : '0;
    assign mem_req   = w_mem_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign grant     = r_grant;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter (timeout path checked when CACHE_ARB_TIMEOUT_EN is defined).
module tb_cache_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              c0_req = 1'b0, c0_we = 1'b0;
    logic [ADDR_W-1:0] c0_addr = '0;
    logic [LINE_W-1:0] c0_wdata = '0;
    logic [LINE_W-1:0] c0_rdata;
    logic              c0_ready;
    logic              c1_req = 1'b0, c1_we = 1'b0;
    logic [ADDR_W-1:0] c1_addr = '0;
    logic [LINE_W-1:0] c1_wdata = '0;
    logic [LINE_W-1:0] c1_rdata;
    logic              c1_ready;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata = '0;
    logic              mem_ready = 1'b0;
    logic [1:0]        grant;
    logic              timeout_err;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [LINE_W-1:0] RD_LINE = 128'hAABBCCDDEEFF00112233445566778899;
    localparam logic [LINE_W-1:0] WB_LINE = 128'h00112233445566778899AABBCCDDEEFF;

    cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_rdata(c0_rdata), .c0_ready(c0_ready),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_rdata(c1_rdata), .c1_ready(c1_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_grant", 128'(grant), 128'h0);
        chk("rst_mem_req", 128'(mem_req), 128'h0);
        chk("rst_mem_addr", 128'(mem_addr), 128'h0);
        chk("rst_mem_wdata", mem_wdata, 128'h0);
        chk("rst_tmo", 128'(timeout_err), 128'h0);
        chk("rst_rdy", 128'({c1_ready, c0_ready}), 128'h0);
        step();
        rst = 1'b0;

        // Refill for client 0, offset stripped from address
        c0_req = 1'b1; c0_we = 1'b0; c0_addr = 32'h0000_0004;
        step();
        @(negedge clk);
        chk("rf_grant", 128'(grant), 128'h1);
        chk("rf_mem_req", 128'(mem_req), 128'h1);
        chk("rf_mem_addr", 128'(mem_addr), 128'h0);
        chk("rf_mem_we", 128'(mem_we), 128'h0);
        chk("rf_no_rdy", 128'(c0_ready), 128'h0);
        step();
        step();
        mem_ready = 1'b1; mem_rdata = RD_LINE;
        @(negedge clk);
        chk("rf_c0_ready", 128'(c0_ready), 128'h1);
        chk("rf_c0_rdata", c0_rdata, RD_LINE);
        chk("rf_c1_ready", 128'(c1_ready), 128'h0);
        step();
        mem_ready = 1'b0; c0_req = 1'b0;
        @(negedge clk);
        chk("rf_grant_idle", 128'(grant), 128'h0);
        chk("rf_ready_once", 128'(c0_ready), 128'h0);
        chk("rf_mem_req_lo", 128'(mem_req), 128'h0);

        // mem_ready while idle produces nothing
        mem_ready = 1'b1;
        #1;
        chk("idle_mr_rdy", 128'({c1_ready, c0_ready}), 128'h0);
        step();
        mem_ready = 1'b0;

        // Fresh reset, then simultaneous requests: client 0 wins
        rst = 1'b1;
        step();
        rst = 1'b0;
        c0_req = 1'b1; c0_we = 1'b0; c0_addr = 32'h0000_0020;
        c1_req = 1'b1; c1_we = 1'b1; c1_addr = 32'h0000_0010; c1_wdata = WB_LINE;
        step();
        @(negedge clk);
        chk("tie_grant_c0", 128'(grant), 128'h1);
        chk("tie_addr_c0", 128'(mem_addr), 128'h20);
        step();
        mem_ready = 1'b1; mem_rdata = RD_LINE;
        @(negedge clk);
        chk("tie_c0_ready", 128'(c0_ready), 128'h1);
        chk("tie_c1_not_rdy", 128'(c1_ready), 128'h0);
        step();
        mem_ready = 1'b0; c0_req = 1'b0;
        @(negedge clk);
        chk("tie_gap", 128'(grant), 128'h0);
        step();
        @(negedge clk);
        chk("wb_grant_c1", 128'(grant), 128'h2);
        chk("wb_mem_we", 128'(mem_we), 128'h1);
        chk("wb_mem_addr", 128'(mem_addr), 128'h10);
        chk("wb_mem_wdata", mem_wdata, WB_LINE);
        // Client inputs changing mid-transaction must not disturb the held copy
        c1_addr = 32'hDEAD_BEEF; c1_wdata = '0;
        #1;
        chk("wb_addr_held", 128'(mem_addr), 128'h10);
        chk("wb_wdata_held", mem_wdata, WB_LINE);
        step();
        mem_ready = 1'b1; mem_rdata = RD_LINE;
        @(negedge clk);
        chk("wb_c1_ready", 128'(c1_ready), 128'h1);
        chk("wb_c1_rdata", c1_rdata, 128'h0);
        chk("wb_c0_ready", 128'(c0_ready), 128'h0);
        step();
        mem_ready = 1'b0; c1_req = 1'b0;
        @(negedge clk);
        chk("wb_grant_idle", 128'(grant), 128'h0);

        // Client 0 holds req one cycle past ready: no duplicate grant
        c0_req = 1'b1; c0_addr = 32'h0000_0104;
        step();
        @(negedge clk);
        chk("mk_grant", 128'(grant), 128'h1);
        step();
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step();
        c0_req = 1'b0;
        @(negedge clk);
        chk("mk_no_regrant", 128'(grant), 128'h0);
        chk("mk_no_mem_req", 128'(mem_req), 128'h0);
        step();
        step();
        c0_req = 1'b1; c0_addr = 32'h0000_0208;
        step();
        @(negedge clk);
        chk("mk_regrant", 128'(grant), 128'h1);
        chk("mk_re_addr", 128'(mem_addr), 128'h200);
        step();
        mem_ready = 1'b1; mem_rdata = WB_LINE;
        @(negedge clk);
        chk("mk_re_rdata", c0_rdata, WB_LINE);
        step();
        mem_ready = 1'b0; c0_req = 1'b0;
        step();

        // Reset in the middle of a client 1 transaction
        c1_req = 1'b1; c1_we = 1'b0; c1_addr = 32'h0000_0030;
        step();
        @(negedge clk);
        chk("mr_grant_c1", 128'(grant), 128'h2);
        step();
        rst = 1'b1; mem_ready = 1'b1;
        #1;
        chk("mr_mem_req", 128'(mem_req), 128'h0);
        chk("mr_grant", 128'(grant), 128'h0);
        chk("mr_ready", 128'({c1_ready, c0_ready}), 128'h0);
        step();
        rst = 1'b0; mem_ready = 1'b0;
        c0_req = 1'b1; c0_we = 1'b0; c0_addr = 32'h0000_0040;
        step();
        @(negedge clk);
        chk("mr_tie_c0", 128'(grant), 128'h1);

        // Client 0 now waits with no memory response
`ifdef CACHE_ARB_TIMEOUT_EN
        begin
            int busy_cycles = 0;
            bit seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                if (c0_ready) begin
                    seen = 1'b1;
                    chk("to_rdata", c0_rdata, 128'h0);
                    chk("to_mem_req", 128'(mem_req), 128'h0);
                end else begin
                    if (mem_req) busy_cycles++;
                    @(negedge clk);
                end
            end
            chk("to_seen", 128'(seen), 128'h1);
            chk("to_busy_cycles", 128'(busy_cycles), 128'd8);
            c0_req = 1'b0;
            @(negedge clk);
            chk("to_err", 128'(timeout_err), 128'h1);
            chk("to_grant", 128'(grant), 128'h0);
            repeat (3) @(negedge clk);
            chk("to_err_sticky", 128'(timeout_err), 128'h1);
        end
`else
        repeat (12) @(negedge clk);
        chk("nt_grant", 128'(grant), 128'h1);
        chk("nt_mem_req", 128'(mem_req), 128'h1);
        chk("nt_no_rdy", 128'(c0_ready), 128'h0);
        chk("nt_err", 128'(timeout_err), 128'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
